// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared FSM state encoding and SPI mode numbering for spi_sclk_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LEAD  = ST_LEAD,
        RUN   = ST_RUN,
        TRAIL = ST_TRAIL
    } spi_state_t;

    // SPI mode number is {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_half_period_cnt.sv
// ============================================================================
// spi_half_period_cnt : counts 0..div and flags expiry on the terminal count
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_half_period_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             expire
);

    localparam logic [DIV_W-1:0] c_one = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;

    assign expire = en && !clr && (r_cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= expire ? '0 : r_cnt + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
// spi_sclk_gen : SPI master serial-clock generator with sample/shift strobes
// Optional abort input enabled by defining SPI_SCLK_ABORT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int BITS_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIV_W-1:0]  div,
    input  logic [BITS_W-1:0] nbits,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_SCLK_ABORT_EN
    input  logic              abort,
`endif
    output logic              sclk,
    output logic              sample_strb,
    output logic              shift_strb,
    output logic              busy,
    output logic              done
);

    localparam logic [BITS_W:0] c_edge_one = (BITS_W+1)'(1);

    spi_state_t        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BITS_W-1:0] r_nbits;
    logic              r_cpol;
    logic              r_cpha;
    logic [BITS_W:0]   r_edge_cnt;
    logic              r_sclk;
    logic              r_sample;
    logic              r_shift;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_abort;
    logic              w_clr;
    logic              w_expire;
    logic [BITS_W:0]   w_next_edge;
    logic              w_last_edge;

    // The done cycle is itself IDLE, so it is excluded here to force a gap
    assign w_accept    = (r_state == IDLE) && start && (nbits != '0) && !r_done;
`ifdef SPI_SCLK_ABORT_EN
    assign w_abort     = abort && (r_state != IDLE);
`else
    assign w_abort     = 1'b0;
`endif
    assign w_clr       = w_accept || w_abort;
    assign w_next_edge = r_edge_cnt + c_edge_one;
    assign w_last_edge = (w_next_edge == {r_nbits, 1'b0});

    spi_half_period_cnt #(
        .DIV_W (DIV_W)
    ) u_half_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (r_state != IDLE),
        .clr    (w_clr),
        .div    (r_div),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_nbits    <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
            r_sample   <= 1'b0;
            r_shift    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            r_shift  <= 1'b0;
            r_done   <= 1'b0;
            if (w_abort) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_sclk     <= r_cpol;
                r_edge_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_sclk <= cpol;
                        if (w_accept) begin
                            r_div      <= div;
                            r_nbits    <= nbits;
                            r_cpol     <= cpol;
                            r_cpha     <= cpha;
                            r_edge_cnt <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= LEAD;
                        end
                    end
                    LEAD: begin
                        if (w_expire) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (w_expire) begin
                            r_sclk     <= ~r_sclk;
                            r_edge_cnt <= w_next_edge;
                            // Odd edge numbers are leading edges
                            if (w_next_edge[0]) begin
                                if (r_cpha) r_shift  <= 1'b1;
                                else        r_sample <= 1'b1;
                            end else begin
                                if (r_cpha)            r_sample <= 1'b1;
                                else if (!w_last_edge) r_shift  <= 1'b1;
                            end
                            if (w_last_edge) begin
                                r_edge_cnt <= '0;
                                r_state    <= TRAIL;
                            end
                        end
                    end
                    TRAIL: begin
                        if (w_expire) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign sclk        = r_sclk;
    assign sample_strb = r_sample;
    assign shift_strb  = r_shift;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
// ============================================================================
// tb_spi_sclk_gen : self-checking bench for spi_sclk_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_sclk_gen;
    import spi_pkg::*;

    localparam int DIV_W  = 8;
    localparam int BITS_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DIV_W-1:0]  div;
    logic [BITS_W-1:0] nbits;
    logic              cpol;
    logic              cpha;
    logic              abort;
    logic              sclk;
    logic              sample_strb;
    logic              shift_strb;
    logic              busy;
    logic              done;

    int n_pass   = 0;
    int n_checks = 0;

    int tog, smp, shf, done_at;

    always #5 clk = ~clk;

    spi_sclk_gen #(
        .DIV_W  (DIV_W),
        .BITS_W (BITS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .div         (div),
        .nbits       (nbits),
        .cpol        (cpol),
        .cpha        (cpha),
`ifdef SPI_SCLK_ABORT_EN
        .abort       (abort),
`endif
        .sclk        (sclk),
        .sample_strb (sample_strb),
        .shift_strb  (shift_strb),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected {sclk, sample, shift, busy, done} c cycles after start was sampled.
    // Lead half period, 2n toggles each one half period apart, trail half period.
    function automatic logic [4:0] model(input int c, input int d, input int nb,
                                         input bit cp, input bit ch);
        int  total;
        int  k;
        int  e;
        bit  lead;
        logic s, sm, sh;
        total = d * (2 * nb + 2);
        e = c / d - 1;
        k = (e < 0) ? 0 : ((e > 2 * nb) ? 2 * nb : e);
        s  = cp ^ k[0];
        sm = 1'b0;
        sh = 1'b0;
        if ((c % d == 0) && e >= 1 && e <= 2 * nb) begin
            lead = e[0];
            sm = ch ? !lead : lead;
            sh = ch ? lead : (!lead && e != 2 * nb);
        end
        return {s, sm, sh, c < total, c == total};
    endfunction

    // Runs one transfer; stop_at>0 ends the run early after that many cycles.
    task automatic run_xfer(input int dv, input int nb, input bit cp, input bit ch,
                            input bit scramble, input int stop_at);
        int   d;
        int   total;
        int   last;
        logic prev;
        d     = dv + 1;
        total = d * (2 * nb + 2);
        last  = (stop_at > 0 && stop_at < total) ? stop_at : total;
        div   = DIV_W'(dv);
        nbits = BITS_W'(nb);
        cpol  = cp;
        cpha  = ch;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_sclk", 32'(sclk), 32'(cp));
        prev = sclk;
        tog = 0; smp = 0; shf = 0; done_at = -1;
        for (int c = 1; c <= last; c++) begin
            if (scramble) begin
                div   = DIV_W'($urandom_range(0, 7));
                nbits = BITS_W'($urandom_range(0, 20));
                cpol  = 1'($urandom);
                cpha  = 1'($urandom);
                start = 1'($urandom);
            end
            tick();
            start = 1'b0;
            check("cycle", 32'({sclk, sample_strb, shift_strb, busy, done}),
                  32'(model(c, d, nb, cp, ch)));
            if (sclk !== prev) tog++;
            prev = sclk;
            if (sample_strb === 1'b1) smp++;
            if (shift_strb === 1'b1) shf++;
            if (done === 1'b1 && done_at < 0) done_at = c;
        end
        if (last == total) begin
            // A start in the done cycle must be ignored
            nbits = BITS_W'(nb);
            start = 1'b1;
            tick();
            start = 1'b0;
            check("done_cycle_start_busy", 32'(busy), 32'd0);
            check("idle_sclk_tracks_cpol", 32'(sclk), 32'(cpol));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; div = '0; nbits = '0;
        cpol = 1'b1; cpha = 1'b0; abort = 1'b0;
        #1;
        check("reset_outputs", 32'({sclk, sample_strb, shift_strb, busy, done}), 32'd0);
        tick();
        tick();
        check("reset_held_sclk", 32'(sclk), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_sclk_follows_cpol", 32'(sclk), 32'd1);
        cpol = 1'b0;
        tick();
        check("idle_sclk_tracks_cpol_low", 32'(sclk), 32'd0);

        // Mode 0, div=1, nbits=8
        run_xfer(1, 8, 1'b0, 1'b0, 1'b0, 0);
        check("m0_toggles", 32'(tog), 32'd16);
        check("m0_samples", 32'(smp), 32'd8);
        check("m0_shifts", 32'(shf), 32'd7);
        check("m0_done_at", 32'(done_at), 32'd36);
        tick();

        // Mode 3, div=0, nbits=4
        cpol = 1'b1;
        tick();
        check("m3_idle_high", 32'(sclk), 32'd1);
        run_xfer(0, 4, 1'b1, 1'b1, 1'b0, 0);
        check("m3_mode_number", 32'(spi_mode(cpol, cpha)), 32'(SPI_MODE3));
        check("m3_toggles", 32'(tog), 32'd8);
        check("m3_samples", 32'(smp), 32'd4);
        check("m3_shifts", 32'(shf), 32'd4);
        check("m3_done_at", 32'(done_at), 32'd10);
        tick();

        // Mode 0 again with live inputs and start scrambled while busy
        run_xfer(1, 8, 1'b0, 1'b0, 1'b1, 0);
        check("scr_toggles", 32'(tog), 32'd16);
        check("scr_done_at", 32'(done_at), 32'd36);
        tick();

        // start with nbits=0 is ignored
        cpol = 1'b1; nbits = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("nbits0_state", 32'({sclk, busy, done}), 32'b100);
            tick();
        end

        // Reset right after the 5th edge (c = 2*6 = 12)
        run_xfer(1, 8, 1'b0, 1'b0, 1'b0, 12);
        check("pre_rst_edges", 32'(tog), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", 32'({sclk, sample_strb, shift_strb, busy, done}), 32'd0);
        cpol = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_held_no_done", 32'({busy, done}), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("rst_release_sclk", 32'(sclk), 32'd1);
        run_xfer(1, 8, 1'b0, 1'b0, 1'b0, 0);
        check("after_rst_done_at", 32'(done_at), 32'd36);
        tick();

`ifdef SPI_SCLK_ABORT_EN
        // Abort raised in the cycle the 3rd edge appears (c = 2*4 = 8)
        run_xfer(1, 8, 1'b1, 1'b0, 1'b0, 8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", 32'({sclk, sample_strb, shift_strb, busy, done}), 32'b10000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", 32'({busy, done}), 32'd0);
        end
        // abort together with start in IDLE: start wins
        abort = 1'b1; nbits = BITS_W'(2); start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) tick();
        check("abort_start_idle_end", 32'(busy), 32'd0);
`endif

        // Randomized transfers against the timing model
        for (int t = 0; t < 12; t++) begin
            int rdv, rnb;
            bit rcp, rch;
            rdv = int'($urandom_range(0, 4));
            rnb = int'($urandom_range(1, 12));
            rcp = 1'($urandom);
            rch = 1'($urandom);
            cpol = rcp;
            tick();
            run_xfer(rdv, rnb, rcp, rch, 1'b1, 0);
            check("rnd_toggles", 32'(tog), 32'(2 * rnb));
            check("rnd_samples", 32'(smp), 32'(rnb));
            check("rnd_shifts", 32'(shf), 32'(rch ? rnb : rnb - 1));
            check("rnd_done_at", 32'(done_at), 32'((rdv + 1) * (2 * rnb + 2)));
            start = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
